block_memory_dp: RTL

Parametrised successor to the 1K x 16 single-port block memory. Provides port A (read/write) and port B (read-only), a selectable read latency, a selectable port-A write mode, and a hardware clear sequencer that zero-fills the array after reset. It sits wherever the processor needs a shared instruction/data store, for example fetch on port B and load/store on port A.

---
 rtl/block_memory_dp.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/block_memory_dp.sv
// ============================================================================
// block_memory_dp
// ----------------------------------------------------------------------------
// Dual-port block memory with a hardware clear sequencer.
//
// Port A is a read/write port, port B is read-only. Both ports share one
// clock. After every reset the clear sequencer writes CLEAR_VALUE to every
// location, one word per edge. While that runs, busy is high and all user
// accesses are ignored.
//
// The array is written from a single write port. That port is shared between
// the clear sequencer and port A, which lets the storage map onto block RAM.
// Each read port has one registered read. With READ_LATENCY=2 a separate
// output register stage follows the read register.
//
// Parameters
//   DATA_WIDTH   : word width in bits
//   ADDR_WIDTH   : address width, DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY : 1 or 2 edges from the access edge to valid output data
//   WRITE_MODE   : 0 = READ_FIRST, 1 = WRITE_FIRST (port A and A-to-B collision)
//   CLEAR_VALUE  : word written everywhere by the clear sequencer
//
// Ports
//   clka        : clock, all logic on the rising edge
//   rsta        : synchronous active-high reset
//   ena / wea   : port A access enable / write enable (wea qualified by ena)
//   addra, dina : port A address / write data
//   douta       : port A read data, holds when douta_valid is low
//   douta_valid : douta carries the result of an accepted port A access
//   enb, addrb  : port B read enable / address
//   doutb       : port B read data, holds when doutb_valid is low
//   doutb_valid : doutb carries the result of an accepted port B read
//   busy        : clear sequence in progress, accesses ignored
// ============================================================================
module block_memory_dp #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  douta_valid,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_ptr;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    acc_a;
    logic                    acc_b;
    logic                    write_a;
    logic                    collide;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   rd_a;
    logic                    rd_a_valid;
    logic [DATA_WIDTH-1:0]   rd_b;
    logic                    rd_b_valid;

    // Accesses are only accepted once the clear has finished and reset is
    // low. Reset has priority over everything, including port A writes.
    always_comb begin
        acc_a   = (state == IDLE) && !rsta && ena;
        acc_b   = (state == IDLE) && !rsta && enb;
        write_a = acc_a && wea;
        collide = write_a && acc_b && (addra == addrb);
    end

    // Clear sequencer. Reset parks it at address 0 with busy high. Each
    // released edge sweeps one word. The edge that writes the last address
    // hands over to IDLE, so busy falls DEPTH edges after release. A reset
    // in the middle of a sweep simply starts it over.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            busy      <= 1'b1;
        end else if (state == CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
            if (clear_ptr == LAST_ADDR) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    // Single write port into the array, shared by the sweep and port A.
    // The two sources never overlap because port A is locked out in CLEAR.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addra;
        mem_wdata = dina;
        if (!rsta && (state == CLEAR)) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr;
            mem_wdata = CLEAR_VALUE;
        end else if (write_a) begin
            mem_we    = 1'b1;
        end
    end

    // The array itself has no reset, so the contents survive while rsta is
    // held and only the sweep changes them.
    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Port A registered read. The non-blocking array write above means a
    // plain array read returns the old word, which is the READ_FIRST result.
    // WRITE_FIRST forwards the incoming data instead.
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_a       <= '0;
            rd_a_valid <= 1'b0;
        end else begin
            rd_a_valid <= acc_a;
            if (acc_a) begin
                if (wea && (WRITE_MODE == 1)) begin
                    rd_a <= dina;
                end else begin
                    rd_a <= mem[addra];
                end
            end
        end
    end

    // Port B registered read. On an address collision with a port A write,
    // WRITE_FIRST forwards dina; READ_FIRST sees the old word naturally.
    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_b       <= '0;
            rd_b_valid <= 1'b0;
        end else begin
            rd_b_valid <= acc_b;
            if (acc_b) begin
                if (collide && (WRITE_MODE == 1)) begin
                    rd_b <= dina;
                end else begin
                    rd_b <= mem[addrb];
                end
            end
        end
    end

    // Optional output register stage. The data register only loads when
    // the stage in front of it carries a valid result, so the outputs hold
    // their last value between accesses.
    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            always_ff @(posedge clka) begin
                if (rsta) begin
                    douta       <= '0;
                    douta_valid <= 1'b0;
                    doutb       <= '0;
                    doutb_valid <= 1'b0;
                end else begin
                    douta_valid <= rd_a_valid;
                    doutb_valid <= rd_b_valid;
                    if (rd_a_valid) begin
                        douta <= rd_a;
                    end
                    if (rd_b_valid) begin
                        doutb <= rd_b;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_comb begin
                douta       = rd_a;
                douta_valid = rd_a_valid;
                doutb       = rd_b;
                doutb_valid = rd_b_valid;
            end
        end
    endgenerate

endmodule
